// File: rtl/alu_req_arbiter.sv
// rtl/alu_req_arbiter.sv - round-robin arbiter sharing one fixed-latency ALU among NREQ requesters
//
// One operation is in flight at a time. A winner is chosen in IDLE, its
// valid/ready handshake completes in GRANT, the ALU result is captured after
// ALU_LAT WAIT cycles and held in RESP until the consumer accepts it.
//
// Ports:
//   clk, rstn                 clock, asynchronous active-low reset
//   req_valid / req_ready     per-requester request handshake (req_ready one-hot)
//   req_op1/op2/opcode        flattened operands, slice i belongs to requester i
//   alu_op1/op2/opcode        registered operands/opcode driven to the ALU
//   alu_result                ALU result input
//   rsp_valid / rsp_ready     response handshake
//   rsp_id, rsp_result        requester index and captured ALU result
//   busy                      high in every state except IDLE
//   grant_cnt                 per-requester saturating 8-bit grant counters,
//                             present only when ALU_REQ_ARBITER_STATS_EN is defined

module alu_req_arbiter #(
  parameter int NREQ    = 4,
  parameter int DW      = 4,
  parameter int OPW     = 3,
  parameter int RW      = 8,
  parameter int ALU_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*DW-1:0]       req_op1,
  input  logic [NREQ*DW-1:0]       req_op2,
  input  logic [NREQ*OPW-1:0]      req_opcode,
  output logic [DW-1:0]            alu_op1,
  output logic [DW-1:0]            alu_op2,
  output logic [OPW-1:0]           alu_opcode,
  input  logic [RW-1:0]            alu_result,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic [RW-1:0]            rsp_result,
`ifdef ALU_REQ_ARBITER_STATS_EN
  output logic [NREQ*8-1:0]        grant_cnt,
`endif
  output logic                     busy
);

  localparam int IDW = $clog2(NREQ);

  typedef enum logic [1:0] {IDLE, GRANT, WAIT, RESP} state_t;

  state_t            state;
  logic [IDW-1:0]    rr_ptr;
  logic [IDW-1:0]    win_idx;
  logic [2:0]        wait_cnt;

  logic [2*NREQ-1:0] dbl_valid;
  logic [NREQ-1:0]   rot_valid;
  logic              pick_found;
  logic [IDW:0]      pick_sum;
  logic [IDW-1:0]    pick;
  logic [IDW-1:0]    next_ptr;

  // Round-robin search: rotate the request vector so rr_ptr sits at bit 0,
  // take the first set bit, then map the offset back to a requester index.
  always_comb begin
    dbl_valid  = {req_valid, req_valid};
    rot_valid  = NREQ'(dbl_valid >> rr_ptr);
    pick_found = 1'b0;
    pick_sum   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!pick_found && rot_valid[k]) begin
        pick_found = 1'b1;
        pick_sum   = {1'b0, rr_ptr} + (IDW+1)'(k);
      end
    end
    if (pick_sum >= (IDW+1)'(NREQ)) begin
      pick_sum = pick_sum - (IDW+1)'(NREQ);
    end
    pick = pick_sum[IDW-1:0];
  end

  assign next_ptr = (win_idx == IDW'(NREQ-1)) ? '0 : win_idx + 1'b1;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      win_idx    <= '0;
      wait_cnt   <= '0;
      req_ready  <= '0;
      alu_op1    <= '0;
      alu_op2    <= '0;
      alu_opcode <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_result <= '0;
      busy       <= 1'b0;
`ifdef ALU_REQ_ARBITER_STATS_EN
      grant_cnt  <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (|req_valid) begin
            req_ready <= {{(NREQ-1){1'b0}}, 1'b1} << pick;
            win_idx   <= pick;
            busy      <= 1'b1;
            state     <= GRANT;
          end
        end
        GRANT: begin
          // Handshake completes this cycle; the requester's operands are
          // trusted without re-checking req_valid.
          alu_op1    <= req_op1[win_idx*DW +: DW];
          alu_op2    <= req_op2[win_idx*DW +: DW];
          alu_opcode <= req_opcode[win_idx*OPW +: OPW];
          rr_ptr     <= next_ptr;
          req_ready  <= '0;
          wait_cnt   <= 3'(ALU_LAT);
          state      <= WAIT;
`ifdef ALU_REQ_ARBITER_STATS_EN
          if (grant_cnt[win_idx*8 +: 8] != 8'hFF) begin
            grant_cnt[win_idx*8 +: 8] <= grant_cnt[win_idx*8 +: 8] + 8'd1;
          end
`endif
        end
        WAIT: begin
          // Capture on the cycle the counter would hit zero, giving
          // ALU_LAT+1 cycles from the grant cycle to rsp_valid.
          if (wait_cnt <= 3'd1) begin
            wait_cnt   <= '0;
            rsp_result <= alu_result;
            rsp_id     <= win_idx;
            rsp_valid  <= 1'b1;
            state      <= RESP;
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_req_arbiter.sv
// tb/tb_alu_req_arbiter.sv - scoreboard bench for alu_req_arbiter

module tb_alu_req_arbiter;

  localparam int NREQ    = 4;
  localparam int DW      = 4;
  localparam int OPW     = 3;
  localparam int RW      = 8;
  localparam int ALU_LAT = 1;

  logic                clk = 1'b0;
  logic                rstn;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*DW-1:0]  req_op1;
  logic [NREQ*DW-1:0]  req_op2;
  logic [NREQ*OPW-1:0] req_opcode;
  logic [DW-1:0]       alu_op1;
  logic [DW-1:0]       alu_op2;
  logic [OPW-1:0]      alu_opcode;
  logic [RW-1:0]       alu_result;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [1:0]          rsp_id;
  logic [RW-1:0]       rsp_result;
  logic                busy;
`ifdef ALU_REQ_ARBITER_STATS_EN
  logic [NREQ*8-1:0]   grant_cnt;
`endif

  logic [DW-1:0]  op1_a [NREQ];
  logic [DW-1:0]  op2_a [NREQ];
  logic [OPW-1:0] opc_a [NREQ];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NREQ; g++) begin : g_pack
    assign req_op1[g*DW +: DW]     = op1_a[g];
    assign req_op2[g*DW +: DW]     = op2_a[g];
    assign req_opcode[g*OPW +: OPW] = opc_a[g];
  end

  function automatic logic [RW-1:0] alu_f(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                          input logic [OPW-1:0] op);
    case (op)
      3'd0:    alu_f = RW'(a) + RW'(b);
      3'd1:    alu_f = RW'(a) - RW'(b);
      3'd2:    alu_f = RW'(a & b);
      3'd3:    alu_f = RW'(a | b);
      3'd4:    alu_f = RW'(a ^ b);
      3'd5:    alu_f = RW'(a) * RW'(b);
      3'd6:    alu_f = RW'(a) << b[1:0];
      default: alu_f = {a, b};
    endcase
  endfunction

  assign alu_result = alu_f(alu_op1, alu_op2, alu_opcode);

  alu_req_arbiter #(.NREQ(NREQ), .DW(DW), .OPW(OPW), .RW(RW), .ALU_LAT(ALU_LAT)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op1    (req_op1),
    .req_op2    (req_op2),
    .req_opcode (req_opcode),
    .alu_op1    (alu_op1),
    .alu_op2    (alu_op2),
    .alu_opcode (alu_opcode),
    .alu_result (alu_result),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
`ifdef ALU_REQ_ARBITER_STATS_EN
    .grant_cnt  (grant_cnt),
`endif
    .busy       (busy)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input bit ok, input string name, input longint act, input longint exp);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: pending set searched in index order starting just after the last winner.
  function automatic int rr_pick(input logic [NREQ-1:0] v, input int ptr);
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (ptr + k) % NREQ;
      if (v[idx]) return idx;
    end
    return 0;
  endfunction

  typedef struct {
    int             id;
    logic [RW-1:0]  res;
  } exp_t;

  exp_t sbq[$];
  int   glog[$];
  int   grant_seen [NREQ];
  int   cyc = 0;
  int   m_grant_cyc = 0;
  int   m_ptr = 0;
  int   exp_id = 0;
  bit   m_idle = 1'b1;
  bit   m_out = 1'b0;
  bit   exp_pend = 1'b0;

  initial for (int i = 0; i < NREQ; i++) grant_seen[i] = 0;

  // Monitor: keeps the arbiter reference (who should win, when the arbiter is
  // free, when the response is due) and checks the DUT against it each cycle.
  always @(negedge clk) begin : mon
    bit   hs;
    bit   exp_rv;
    exp_t e;
    hs = 1'b0;
    if (!rstn) begin
      m_idle   = 1'b1;
      m_out    = 1'b0;
      exp_pend = 1'b0;
      m_ptr    = 0;
      sbq.delete();
    end else begin
      cyc++;
      for (int i = 0; i < NREQ; i++) begin
        if (req_ready[i] && req_valid[i]) begin
          grant_seen[i]++;
          glog.push_back(i);
        end
      end
      if (exp_pend) begin
        check(req_ready == (4'b0001 << exp_id), "grant_onehot", req_ready, 4'b0001 << exp_id);
        e.id  = exp_id;
        e.res = alu_f(op1_a[exp_id], op2_a[exp_id], opc_a[exp_id]);
        sbq.push_back(e);
        m_grant_cyc = cyc;
        m_out       = 1'b1;
        m_idle      = 1'b0;
        m_ptr       = (exp_id + 1) % NREQ;
        exp_pend    = 1'b0;
      end else begin
        check(req_ready == '0, "no_grant", req_ready, 0);
      end
      check(busy == !m_idle, "busy", busy, !m_idle);
      exp_rv = m_out && (cyc >= m_grant_cyc + ALU_LAT + 1);
      check(rsp_valid == exp_rv, "rsp_valid", rsp_valid, exp_rv);
      if (rsp_valid && exp_rv && sbq.size() > 0) begin
        check(int'(rsp_id) == sbq[0].id, "rsp_id", rsp_id, sbq[0].id);
        check(rsp_result == sbq[0].res, "rsp_result", rsp_result, sbq[0].res);
        if (rsp_ready) begin
          void'(sbq.pop_front());
          m_out = 1'b0;
          hs    = 1'b1;
        end
      end
      if (m_idle && req_valid != '0) begin
        exp_pend = 1'b1;
        exp_id   = rr_pick(req_valid, m_ptr);
      end
      if (hs) m_idle = 1'b1;
    end
  end

  // Stimulus side
  logic [NREQ-1:0] persist;
  bit              rand_mode;
  int              consumed [NREQ];

  task automatic new_ops(input int i);
    op1_a[i] = DW'($urandom);
    op2_a[i] = DW'($urandom);
    opc_a[i] = OPW'($urandom);
  endtask

  // Advance one cycle; inputs change 2 time units after the rising edge.
  task automatic nc();
    @(posedge clk);
    #2;
    for (int i = 0; i < NREQ; i++) begin
      if (consumed[i] != grant_seen[i]) begin
        consumed[i] = grant_seen[i];
        if (persist[i]) new_ops(i);
        else req_valid[i] = 1'b0;
      end
      if (rand_mode && !req_valid[i] && $urandom_range(0, 3) == 0) begin
        new_ops(i);
        req_valid[i] = 1'b1;
      end
    end
    if (rand_mode) rsp_ready = ($urandom_range(0, 2) != 0);
  endtask

  task automatic wait_grants(input int target, input int budget);
    int n;
    n = 0;
    while (glog.size() < target && n < budget) begin
      nc();
      n++;
    end
    check(glog.size() >= target, "grant_timeout", glog.size(), target);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    bit done;
    n = 0;
    done = (req_valid == '0) && m_idle && !exp_pend && (sbq.size() == 0);
    while (!done && n < budget) begin
      nc();
      n++;
      done = (req_valid == '0) && m_idle && !exp_pend && (sbq.size() == 0);
    end
    check(done, "drain_timeout", n, budget);
  endtask

  initial begin : main
    int base;
    int n;
    logic [RW-1:0] exp_r;

    rstn      = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    persist   = '0;
    rand_mode = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      op1_a[i] = '0;
      op2_a[i] = '0;
      opc_a[i] = '0;
      consumed[i] = 0;
    end

    // Reset values
    repeat (2) nc();
    check(req_ready == '0, "rst_req_ready", req_ready, 0);
    check(alu_op1 == '0, "rst_alu_op1", alu_op1, 0);
    check(alu_op2 == '0, "rst_alu_op2", alu_op2, 0);
    check(alu_opcode == '0, "rst_alu_opcode", alu_opcode, 0);
    check(rsp_valid == 1'b0, "rst_rsp_valid", rsp_valid, 0);
    check(rsp_id == '0, "rst_rsp_id", rsp_id, 0);
    check(rsp_result == '0, "rst_rsp_result", rsp_result, 0);
    check(busy == 1'b0, "rst_busy", busy, 0);
    rstn = 1'b1;
    nc();
    check(busy == 1'b0, "idle_busy", busy, 0);

    // Single request with boundary operands
    rsp_ready = 1'b1;
    op1_a[0] = 4'h0;
    op2_a[0] = 4'hF;
    opc_a[0] = 3'b111;
    req_valid = 4'b0001;
    wait_grants(1, 10);
    check(alu_op1 == 4'h0, "single_alu_op1", alu_op1, 4'h0);
    check(alu_op2 == 4'hF, "single_alu_op2", alu_op2, 4'hF);
    check(alu_opcode == 3'd7, "single_alu_opcode", alu_opcode, 7);
    nc();
    check(rsp_valid == 1'b1, "single_rsp_valid", rsp_valid, 1);
    check(rsp_id == 2'd0, "single_rsp_id", rsp_id, 0);
    check(rsp_result == 8'h0F, "single_rsp_result", rsp_result, 8'h0F);
    wait_idle(20);

    // Reset in the middle of an operation
    new_ops(2);
    req_valid[2] = 1'b1;
    wait_grants(glog.size() + 1, 10);
    rstn = 1'b0;
    nc();
    check(busy == 1'b0, "midrst_busy", busy, 0);
    check(rsp_valid == 1'b0, "midrst_rsp_valid", rsp_valid, 0);
    check(req_ready == '0, "midrst_req_ready", req_ready, 0);
    nc();
    rstn = 1'b1;
    new_ops(0);
    new_ops(3);
    req_valid = 4'b1001;
    wait_grants(glog.size() + 1, 10);
    check(glog[glog.size()-1] == 0, "ptr_after_reset", glog[glog.size()-1], 0);
    wait_idle(30);

    // Round-robin with all requesters held pending
    base = glog.size();
    for (int i = 0; i < NREQ; i++) new_ops(i);
    persist   = 4'hF;
    req_valid = 4'hF;
    wait_grants(base + 5, 40);
    for (int k = 0; k < 5; k++) begin
      check(glog[base+k] == k % NREQ, "rr_order", glog[base+k], k % NREQ);
    end
    persist = '0;
    wait_idle(60);

    // Response backpressure
    rsp_ready = 1'b0;
    new_ops(1);
    exp_r = alu_f(op1_a[1], op2_a[1], opc_a[1]);
    req_valid = 4'b0010;
    n = 0;
    while (!rsp_valid && n < 10) begin
      nc();
      n++;
    end
    check(rsp_valid == 1'b1, "bp_rsp_arrive", rsp_valid, 1);
    new_ops(2);
    req_valid[2] = 1'b1;
    repeat (5) begin
      nc();
      check(rsp_valid == 1'b1, "bp_hold_valid", rsp_valid, 1);
      check(rsp_id == 2'd1, "bp_hold_id", rsp_id, 1);
      check(rsp_result == exp_r, "bp_hold_result", rsp_result, exp_r);
      check(req_ready == '0, "bp_no_grant", req_ready, 0);
    end
    rsp_ready = 1'b1;
    nc();
    check(rsp_valid == 1'b0, "bp_rsp_drop", rsp_valid, 0);
    check(req_ready == '0, "bp_idle_gap", req_ready, 0);
    nc();
    check(req_ready == 4'b0100, "bp_next_grant", req_ready, 4'b0100);
    wait_idle(20);

    // Wrap and skip from rr_ptr=3
    base = glog.size();
    new_ops(0);
    new_ops(2);
    req_valid = 4'b0101;
    wait_grants(base + 2, 20);
    check(glog[base] == 0, "wrap_first", glog[base], 0);
    check(glog[base+1] == 2, "wrap_second", glog[base+1], 2);
    wait_idle(20);

    // Randomized traffic and backpressure
    rand_mode = 1'b1;
    repeat (800) nc();
    rand_mode = 1'b0;
    rsp_ready = 1'b1;
    wait_idle(200);

`ifdef ALU_REQ_ARBITER_STATS_EN
    // Counter saturation with a lone requester
    rstn = 1'b0;
    nc();
    nc();
    rstn = 1'b1;
    base = glog.size();
    new_ops(1);
    persist   = 4'b0010;
    req_valid = 4'b0010;
    wait_grants(base + 300, 1400);
    persist = '0;
    wait_idle(20);
    check(grant_cnt[15:8] == 8'd255, "stats_sat", grant_cnt[15:8], 255);
    check(grant_cnt[7:0] == 8'd0, "stats_r0", grant_cnt[7:0], 0);
    check(grant_cnt[23:16] == 8'd0, "stats_r2", grant_cnt[23:16], 0);
    check(grant_cnt[31:24] == 8'd0, "stats_r3", grant_cnt[31:24], 0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
